// File: rtl/global_typs_pkg.sv
// Shared UDP/IPv4 TX types, protocol constants and the header byte-select helper.
// Optional build feature: UDP_TX_LEN_CHECK_EN (payload length enforcement in udp_tx_framer).
package global_typs_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned PORT_W    = 16;
  localparam int unsigned LEN_W     = 16;
  localparam int unsigned IP_ADDR_W = 32;
  localparam int unsigned HDR_BYTES = 8;
  localparam int unsigned HDR_CNT_W = 3;

  localparam logic [BYTE_W-1:0] UDP_PROTOCOL    = 8'h11;
  localparam logic [LEN_W-1:0]  UDP_HDR_LEN     = 16'd8;
  localparam logic [LEN_W-1:0]  UDP_MAX_PAYLOAD = 16'd65527;

  typedef enum logic [1:0] {
    TX_IDLE    = 2'd0,
    TX_SENDING = 2'd1,
    TX_ERR     = 2'd2,
    TX_SUCCESS = 2'd3
  } tx_result_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND_HDR  = 2'd1,
    ST_SEND_DATA = 2'd2
  } udp_tx_state_e;

  typedef struct packed {
    logic              data_out_valid;
    logic              data_out_last;
    logic [BYTE_W-1:0] data_out;
  } tx_data_type;

  typedef struct packed {
    logic [IP_ADDR_W-1:0] dst_ip_addr;
    logic [PORT_W-1:0]    dst_port;
    logic [PORT_W-1:0]    src_port;
    logic [LEN_W-1:0]     data_length;
    logic [LEN_W-1:0]     checksum;
  } udp_tx_header_type;

  typedef struct packed {
    udp_tx_header_type hdr;
    tx_data_type       data;
  } udp_tx_type;

  typedef struct packed {
    logic [BYTE_W-1:0]    protocol;
    logic [LEN_W-1:0]     data_length;
    logic [IP_ADDR_W-1:0] dst_ip_addr;
  } ipv4_tx_header_type;

  typedef struct packed {
    ipv4_tx_header_type hdr;
    tx_data_type        data;
  } ipv4_tx_type;

  // The 8 header bytes as they appear on the wire, MSB-first.
  typedef struct packed {
    logic [PORT_W-1:0] src_port;
    logic [PORT_W-1:0] dst_port;
    logic [LEN_W-1:0]  udp_length;
    logic [LEN_W-1:0]  checksum;
  } udp_wire_hdr_t;

  function automatic logic [BYTE_W-1:0] wire_hdr_byte(input udp_wire_hdr_t h,
                                                      input logic [HDR_CNT_W-1:0] idx);
    logic [63:0] flat;
    flat = h;
    return BYTE_W'(flat >> {3'(3'd7 - idx), 3'b000});
  endfunction

endpackage

// File: rtl/udp_hdr_ser.sv
// Serializes the 8-byte UDP header; the byte index advances once per accepted byte.
module udp_hdr_ser
  import global_typs_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                advance,
  input  udp_wire_hdr_t       hdr,
  output logic [BYTE_W-1:0]   byte_c,
  output logic                final_c
);

  logic [HDR_CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clear)        cnt_d = '0;
    else if (advance) cnt_d = cnt_q + HDR_CNT_W'(1);
  end

  assign byte_c  = wire_hdr_byte(hdr, cnt_q);
  assign final_c = (cnt_q == HDR_CNT_W'(HDR_BYTES - 1));

endmodule

// File: rtl/udp_tx_framer.sv
// UDP transmit framer: prepends the 8-byte UDP header and streams the payload to IPv4 TX.
// Define UDP_TX_LEN_CHECK_EN to enforce the header data_length against the user's last flag.
module udp_tx_framer
  import global_typs_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        udp_tx_start,
  input  udp_tx_type  udp_txi,
  output tx_result_t  udp_tx_result,
  output logic        udp_tx_data_out_ready,
  output logic        ip_tx_start,
  output ipv4_tx_type ip_tx,
  input  tx_result_t  ip_tx_result,
  input  logic        ip_tx_data_out_ready
);

  udp_tx_state_e      state_q, state_d;
  udp_wire_hdr_t      wire_q, wire_d;
  ipv4_tx_header_type ip_hdr_q, ip_hdr_d;
  tx_result_t         result_q, result_d;
  logic               start_q, start_d;

  logic              ip_err;
  logic              xfer;
  logic              hdr_adv;
  logic              hdr_final;
  logic              len_zero;
  logic              len_bad;
  logic              user_last;
  logic              frame_done;
  logic              frame_ok;
  logic [BYTE_W-1:0] hdr_byte;

`ifdef UDP_TX_LEN_CHECK_EN
  logic [LEN_W-1:0] pay_cnt_q, pay_cnt_d;
  logic             pay_final;

  assign pay_final  = (pay_cnt_q == LEN_W'(wire_q.udp_length - UDP_HDR_LEN - 16'd1));
  assign frame_done = pay_final | user_last;
  assign frame_ok   = pay_final & user_last;
`else
  assign frame_done = user_last;
  assign frame_ok   = 1'b1;
`endif

  assign ip_err    = (ip_tx_result == TX_ERR);
  assign len_zero  = (wire_q.udp_length == UDP_HDR_LEN);
  assign len_bad   = (udp_txi.hdr.data_length > UDP_MAX_PAYLOAD);
  assign user_last = udp_txi.data.data_out_last;
  assign xfer      = ip_tx.data.data_out_valid & ip_tx_data_out_ready;
  assign hdr_adv   = (state_q == ST_SEND_HDR) & xfer;

  udp_hdr_ser u_hdr_ser (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_q == ST_IDLE),
    .advance (hdr_adv),
    .hdr     (wire_q),
    .byte_c  (hdr_byte),
    .final_c (hdr_final)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      wire_q    <= '0;
      ip_hdr_q  <= '0;
      result_q  <= TX_IDLE;
      start_q   <= 1'b0;
`ifdef UDP_TX_LEN_CHECK_EN
      pay_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      wire_q    <= wire_d;
      ip_hdr_q  <= ip_hdr_d;
      result_q  <= result_d;
      start_q   <= start_d;
`ifdef UDP_TX_LEN_CHECK_EN
      pay_cnt_q <= pay_cnt_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (udp_tx_start && !len_bad) state_d = ST_SEND_HDR;
      ST_SEND_HDR: begin
        if (ip_err)                 state_d = ST_IDLE;
        else if (xfer && hdr_final) state_d = len_zero ? ST_IDLE : ST_SEND_DATA;
      end
      ST_SEND_DATA: begin
        if (ip_err)                  state_d = ST_IDLE;
        else if (xfer && frame_done) state_d = ST_IDLE;
      end
      default:                       state_d = ST_IDLE;
    endcase
  end

  // Datapath register updates: header latch, launch pulse, result, payload count.
  always_comb begin
    wire_d    = wire_q;
    ip_hdr_d  = ip_hdr_q;
    result_d  = result_q;
    start_d   = 1'b0;
`ifdef UDP_TX_LEN_CHECK_EN
    pay_cnt_d = pay_cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (udp_tx_start) begin
          if (len_bad) begin
            result_d = TX_ERR;
          end else begin
            wire_d.src_port      = udp_txi.hdr.src_port;
            wire_d.dst_port      = udp_txi.hdr.dst_port;
            wire_d.udp_length    = LEN_W'(udp_txi.hdr.data_length + UDP_HDR_LEN);
            wire_d.checksum      = udp_txi.hdr.checksum;
            ip_hdr_d.protocol    = UDP_PROTOCOL;
            ip_hdr_d.data_length = LEN_W'(udp_txi.hdr.data_length + UDP_HDR_LEN);
            ip_hdr_d.dst_ip_addr = udp_txi.hdr.dst_ip_addr;
            result_d             = TX_SENDING;
            start_d              = 1'b1;
`ifdef UDP_TX_LEN_CHECK_EN
            pay_cnt_d            = '0;
`endif
          end
        end
      end
      ST_SEND_HDR: begin
        if (ip_err)                             result_d = TX_ERR;
        else if (xfer && hdr_final && len_zero) result_d = TX_SUCCESS;
      end
      ST_SEND_DATA: begin
        if (ip_err) begin
          result_d = TX_ERR;
        end else if (xfer) begin
`ifdef UDP_TX_LEN_CHECK_EN
          pay_cnt_d = pay_cnt_q + LEN_W'(1);
`endif
          if (frame_done) result_d = frame_ok ? TX_SUCCESS : TX_ERR;
        end
      end
      default: result_d = result_q;
    endcase
  end

  // Outputs: header bytes from the serializer, payload passed straight through.
  always_comb begin
    ip_tx.data            = '0;
    ip_tx.hdr             = ip_hdr_q;
    udp_tx_data_out_ready = 1'b0;
    unique case (state_q)
      ST_SEND_HDR: begin
        if (!ip_err) begin
          ip_tx.data.data_out_valid = 1'b1;
          ip_tx.data.data_out       = hdr_byte;
          ip_tx.data.data_out_last  = hdr_final & len_zero;
        end
      end
      ST_SEND_DATA: begin
        if (!ip_err) begin
          ip_tx.data.data_out_valid = udp_txi.data.data_out_valid;
          ip_tx.data.data_out       = udp_txi.data.data_out;
          ip_tx.data.data_out_last  = frame_done;
          udp_tx_data_out_ready     = ip_tx_data_out_ready;
        end
      end
      default: ip_tx.data = '0;
    endcase
  end

  assign ip_tx_start   = start_q;
  assign udp_tx_result = result_q;

endmodule

// File: tb/tb_udp_tx_framer.sv
// Directed self-checking bench for udp_tx_framer; honours UDP_TX_LEN_CHECK_EN if defined.
module tb_udp_tx_framer;
  import global_typs_pkg::*;

  logic        clk;
  logic        reset;
  logic        udp_tx_start;
  udp_tx_type  udp_txi;
  tx_result_t  udp_tx_result;
  logic        udp_tx_data_out_ready;
  logic        ip_tx_start;
  ipv4_tx_type ip_tx;
  tx_result_t  ip_tx_result;
  logic        ip_tx_data_out_ready;

  udp_tx_framer dut (
    .clk                   (clk),
    .reset                 (reset),
    .udp_tx_start          (udp_tx_start),
    .udp_txi               (udp_txi),
    .udp_tx_result         (udp_tx_result),
    .udp_tx_data_out_ready (udp_tx_data_out_ready),
    .ip_tx_start           (ip_tx_start),
    .ip_tx                 (ip_tx),
    .ip_tx_result          (ip_tx_result),
    .ip_tx_data_out_ready  (ip_tx_data_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] pl [16];
  logic [7:0] got [$];
  logic       got_last [$];
  int         n_start;
  int         saw_ready;
  int         unstable;
  int         valid_during_err;
  int         timeout;
  ipv4_tx_header_type zero_hdr;

  // Runs one datagram: drives header/payload, acts as the IPv4 sink, records accepted bytes.
  task automatic run_frame(input logic [15:0] sp, input logic [15:0] dp, input logic [15:0] len,
                           input logic [15:0] cs, input int n, input int ulast, input int rdy_mode,
                           input int err_after, input int spur);
    int  cyc;
    int  p_idx;
    bit  hold_valid;
    logic [7:0] hold_byte;
    got.delete();
    got_last.delete();
    n_start = 0; saw_ready = 0; unstable = 0; valid_during_err = 0; timeout = 0;
    @(negedge clk);
    udp_txi.hdr.dst_ip_addr = 32'h0A000002;
    udp_txi.hdr.src_port    = sp;
    udp_txi.hdr.dst_port    = dp;
    udp_txi.hdr.data_length = len;
    udp_txi.hdr.checksum    = cs;
    udp_tx_start = 1'b1;
    @(negedge clk);
    udp_tx_start = 1'b0;
    cyc = 0; p_idx = 0; hold_valid = 0; hold_byte = '0;
    while (cyc < 200) begin
      ip_tx_data_out_ready = (rdy_mode == 0) ? 1'b1 : ((cyc % 2) == 0);
      if (err_after >= 0 && got.size() >= err_after) ip_tx_result = TX_ERR;
      udp_tx_start = (spur != 0 && cyc == 3);
      if (spur != 0 && cyc == 3) udp_txi.hdr.src_port = 16'hFFFF;
      udp_txi.data.data_out_valid = (p_idx < n);
      udp_txi.data.data_out       = (p_idx < n) ? pl[p_idx] : 8'h00;
      udp_txi.data.data_out_last  = (p_idx == ulast);
      #1;
      if (ip_tx_start) n_start++;
      if (udp_tx_data_out_ready) saw_ready = 1;
      if (ip_tx_result == TX_ERR && (ip_tx.data.data_out_valid || udp_tx_data_out_ready))
        valid_during_err++;
      if (hold_valid && !(ip_tx.data.data_out_valid && ip_tx.data.data_out == hold_byte))
        unstable++;
      hold_valid = 0;
      if (ip_tx.data.data_out_valid) begin
        if (ip_tx_data_out_ready) begin
          got.push_back(ip_tx.data.data_out);
          got_last.push_back(ip_tx.data.data_out_last);
        end else begin
          hold_valid = 1;
          hold_byte  = ip_tx.data.data_out;
        end
      end
      if (udp_tx_data_out_ready && udp_txi.data.data_out_valid) p_idx++;
      @(negedge clk);
      cyc++;
      if (udp_tx_result != TX_SENDING) break;
    end
    timeout = (cyc >= 200);
    ip_tx_result = TX_IDLE;
    udp_tx_start = 1'b0;
    ip_tx_data_out_ready = 1'b1;
    udp_txi.data = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (udp_tx_result !== TX_IDLE) begin errors++; $display("FAIL reset_result got=%0d exp=%0d", udp_tx_result, TX_IDLE); end
    checks++; if (ip_tx_start !== 1'b0) begin errors++; $display("FAIL reset_start got=%b exp=0", ip_tx_start); end
    checks++; if (ip_tx.data.data_out_valid !== 1'b0 || ip_tx.data.data_out_last !== 1'b0) begin errors++; $display("FAIL reset_valid_last got=%b%b exp=00", ip_tx.data.data_out_valid, ip_tx.data.data_out_last); end
    checks++; if (udp_tx_data_out_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", udp_tx_data_out_ready); end
    checks++; if (ip_tx.hdr !== zero_hdr) begin errors++; $display("FAIL reset_hdr got=%h exp=0", ip_tx.hdr); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] exp [12];
    exp = '{8'h04, 8'hD2, 8'h00, 8'h50, 8'h00, 8'h0C, 8'hBE, 8'hEF, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    pl[0] = 8'hAA; pl[1] = 8'hBB; pl[2] = 8'hCC; pl[3] = 8'hDD;
    run_frame(16'd1234, 16'd80, 16'd4, 16'hBEEF, 4, 3, 0, -1, 0);
    checks++; if (timeout !== 0) begin errors++; $display("FAIL basic_timeout got=%0d exp=0", timeout); end
    checks++; if (got.size() !== 12) begin errors++; $display("FAIL basic_count got=%0d exp=12", got.size()); end
    for (int i = 0; i < 12 && i < got.size(); i++) begin
      checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL basic_byte%0d got=%h exp=%h", i, got[i], exp[i]); end
    end
    for (int i = 0; i < got.size(); i++) begin
      checks++; if (got_last[i] !== (i == 11)) begin errors++; $display("FAIL basic_last%0d got=%b exp=%b", i, got_last[i], (i == 11)); end
    end
    checks++; if (udp_tx_result !== TX_SUCCESS) begin errors++; $display("FAIL basic_result got=%0d exp=%0d", udp_tx_result, TX_SUCCESS); end
    checks++; if (n_start !== 1) begin errors++; $display("FAIL basic_start_pulses got=%0d exp=1", n_start); end
    checks++; if (ip_tx.hdr.protocol !== 8'h11 || ip_tx.hdr.data_length !== 16'd12 || ip_tx.hdr.dst_ip_addr !== 32'h0A000002)
      begin errors++; $display("FAIL basic_iphdr got=%h exp=11000c0a000002", ip_tx.hdr); end
  endtask

  task automatic test_zero_len();
    logic [7:0] exp [8];
    exp = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h08, 8'h01, 8'h02};
    run_frame(16'h1234, 16'h5678, 16'd0, 16'h0102, 0, -1, 0, -1, 0);
    checks++; if (got.size() !== 8) begin errors++; $display("FAIL zero_count got=%0d exp=8", got.size()); end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      checks++; if (got[i] !== exp[i] || got_last[i] !== (i == 7)) begin errors++; $display("FAIL zero_byte%0d got=%h/%b exp=%h/%b", i, got[i], got_last[i], exp[i], (i == 7)); end
    end
    checks++; if (saw_ready !== 0) begin errors++; $display("FAIL zero_user_ready got=%0d exp=0", saw_ready); end
    checks++; if (udp_tx_result !== TX_SUCCESS) begin errors++; $display("FAIL zero_result got=%0d exp=%0d", udp_tx_result, TX_SUCCESS); end
    checks++; if (ip_tx.hdr.data_length !== 16'd8) begin errors++; $display("FAIL zero_iplen got=%0d exp=8", ip_tx.hdr.data_length); end
  endtask

  task automatic test_toggle_ready();
    logic [7:0] exp [11];
    exp = '{8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h0B, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33};
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    run_frame(16'h0001, 16'h0002, 16'd3, 16'h0000, 3, 2, 1, -1, 0);
    checks++; if (got.size() !== 11) begin errors++; $display("FAIL toggle_count got=%0d exp=11", got.size()); end
    for (int i = 0; i < 11 && i < got.size(); i++) begin
      checks++; if (got[i] !== exp[i] || got_last[i] !== (i == 10)) begin errors++; $display("FAIL toggle_byte%0d got=%h/%b exp=%h/%b", i, got[i], got_last[i], exp[i], (i == 10)); end
    end
    checks++; if (unstable !== 0) begin errors++; $display("FAIL toggle_stable got=%0d exp=0", unstable); end
    checks++; if (udp_tx_result !== TX_SUCCESS) begin errors++; $display("FAIL toggle_result got=%0d exp=%0d", udp_tx_result, TX_SUCCESS); end
  endtask

  task automatic test_ip_err();
    pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'h03; pl[3] = 8'h04;
    run_frame(16'h0A0A, 16'h0B0B, 16'd4, 16'h1111, 4, 3, 0, 5, 0);
    checks++; if (got.size() !== 5) begin errors++; $display("FAIL iperr_count got=%0d exp=5", got.size()); end
    checks++; if (valid_during_err !== 0) begin errors++; $display("FAIL iperr_valid got=%0d exp=0", valid_during_err); end
    checks++; if (udp_tx_result !== TX_ERR) begin errors++; $display("FAIL iperr_result got=%0d exp=%0d", udp_tx_result, TX_ERR); end
    udp_txi.data.data_out_valid = 1'b1;
    #1;
    checks++; if (ip_tx.data.data_out_valid !== 1'b0 || udp_tx_data_out_ready !== 1'b0) begin errors++; $display("FAIL iperr_idle got=%b%b exp=00", ip_tx.data.data_out_valid, udp_tx_data_out_ready); end
    udp_txi.data = '0;
  endtask

  task automatic test_len_err();
    @(negedge clk);
    udp_txi.hdr.data_length = 16'd65528;
    udp_tx_start = 1'b1;
    @(negedge clk);
    udp_tx_start = 1'b0;
    checks++; if (udp_tx_result !== TX_ERR) begin errors++; $display("FAIL lenerr_result got=%0d exp=%0d", udp_tx_result, TX_ERR); end
    checks++; if (ip_tx_start !== 1'b0) begin errors++; $display("FAIL lenerr_start got=%b exp=0", ip_tx_start); end
    repeat (3) @(negedge clk);
    checks++; if (ip_tx.data.data_out_valid !== 1'b0 || udp_tx_result !== TX_ERR) begin errors++; $display("FAIL lenerr_hold got=%b/%0d exp=0/%0d", ip_tx.data.data_out_valid, udp_tx_result, TX_ERR); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [10];
    exp = '{8'hAB, 8'hCD, 8'h00, 8'h35, 8'h00, 8'h0A, 8'h55, 8'h66, 8'h77, 8'h88};
    pl[0] = 8'h77; pl[1] = 8'h88;
    run_frame(16'hABCD, 16'h0035, 16'd2, 16'h5566, 2, 1, 0, -1, 1);
    checks++; if (n_start !== 1) begin errors++; $display("FAIL b2b_start_pulses got=%0d exp=1", n_start); end
    checks++; if (got.size() !== 10) begin errors++; $display("FAIL b2b_count got=%0d exp=10", got.size()); end
    for (int i = 0; i < 10 && i < got.size(); i++) begin
      checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, got[i], exp[i]); end
    end
    pl[0] = 8'h99;
    run_frame(16'h0001, 16'h0001, 16'd1, 16'h0000, 1, 0, 0, -1, 0);
    checks++; if (got.size() !== 9 || udp_tx_result !== TX_SUCCESS) begin errors++; $display("FAIL b2b_second got=%0d/%0d exp=9/%0d", got.size(), udp_tx_result, TX_SUCCESS); end
  endtask

  task automatic test_early_last();
    pl[0] = 8'hAA; pl[1] = 8'hBB; pl[2] = 8'hCC; pl[3] = 8'hDD;
    run_frame(16'd1234, 16'd80, 16'd4, 16'hBEEF, 4, 1, 0, -1, 0);
    checks++; if (got.size() !== 10) begin errors++; $display("FAIL early_count got=%0d exp=10", got.size()); end
    if (got.size() == 10) begin
      checks++; if (got_last[9] !== 1'b1 || got[9] !== 8'hBB) begin errors++; $display("FAIL early_last got=%h/%b exp=bb/1", got[9], got_last[9]); end
    end
`ifdef UDP_TX_LEN_CHECK_EN
    checks++; if (udp_tx_result !== TX_ERR) begin errors++; $display("FAIL early_result got=%0d exp=%0d", udp_tx_result, TX_ERR); end
`else
    checks++; if (udp_tx_result !== TX_SUCCESS) begin errors++; $display("FAIL early_result got=%0d exp=%0d", udp_tx_result, TX_SUCCESS); end
`endif
  endtask

  task automatic test_reset_mid();
    int bad;
    bad = 0;
    pl[0] = 8'h42;
    @(negedge clk);
    udp_txi.hdr.data_length = 16'd4;
    udp_tx_start = 1'b1;
    @(negedge clk);
    udp_tx_start = 1'b0;
    udp_txi.data.data_out_valid = 1'b1;
    udp_txi.data.data_out = 8'h42;
    udp_txi.data.data_out_last = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (udp_tx_result !== TX_IDLE || ip_tx.hdr !== zero_hdr) begin errors++; $display("FAIL midreset_state got=%0d/%h exp=%0d/0", udp_tx_result, ip_tx.hdr, TX_IDLE); end
    for (int i = 0; i < 4; i++) begin
      #1;
      if (ip_tx.data.data_out_valid || ip_tx.data.data_out_last || ip_tx_start || udp_tx_data_out_ready) bad++;
      @(negedge clk);
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL midreset_quiet got=%0d exp=0", bad); end
    udp_txi.data = '0;
  endtask

  initial begin
    zero_hdr = '0;
    reset = 1'b1;
    udp_tx_start = 1'b0;
    udp_txi = '0;
    ip_tx_result = TX_IDLE;
    ip_tx_data_out_ready = 1'b1;
    test_reset();
    test_basic();
    test_zero_len();
    test_toggle_ready();
    test_ip_err();
    test_len_err();
    test_back_to_back();
    test_early_last();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
